// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter / phase sequencer.
package pc_seq_pkg;

  // Sequencer run state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } seq_state_e;

  // Width of a phase counter that counts 0..phases-1 (at least one bit)
  function automatic int phase_width(input int phases);
    return (phases > 1) ? $clog2(phases) : 1;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Wrapping phase counter: counts 0..PHASES-1 while enabled, clear forces 0.
module phase_counter
  import pc_seq_pkg::*;
#(
  parameter  int PHASES = 7,
  localparam int TW     = phase_width(PHASES)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          en,
  input  logic          clr,
  output logic [TW-1:0] tick,
  output logic          last
);

  logic [TW-1:0] tick_q;
  logic [TW-1:0] tick_d;

  assign last = (tick_q == TW'(PHASES - 1));
  assign tick = tick_q;

  // Next phase: clear wins, otherwise step and wrap after the last phase
  always_comb begin
    tick_d = tick_q;
    if (clr) begin
      tick_d = '0;
    end else if (en) begin
      tick_d = last ? '0 : tick_q + TW'(1);
    end
  end

  // Phase register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and phase sequencer: run/halt FSM, PC commit with a
// one-entry redirect buffer, and a retired-instruction counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter  int              XLEN     = 32,
  parameter  int              PHASES   = 7,
  parameter  int              INC      = 4,
  parameter  logic [XLEN-1:0] RESET_PC = '0,
  localparam int              TW       = phase_width(PHASES)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            run,
  input  logic            halt_req,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic [TW-1:0]   tick,
  output logic            running,
  output logic            commit,
  output logic [31:0]     retired
);

  seq_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redir_buf_q, redir_buf_d;
  logic            redir_pend_q, redir_pend_d;
  logic            halt_pend_q, halt_pend_d;
  logic [31:0]     retired_q, retired_d;
  logic [XLEN-1:0] next_pc;
  logic            phase_last;
  logic            halt_now;

  assign running = (state_q == RUN);
  assign commit  = running && !stall && phase_last;
  assign pc      = pc_q;
  assign retired = retired_q;

  // Phase counter steps only while running unstalled and sits at 0 otherwise,
  // so every entry into RUN starts at phase 0
  phase_counter #(
    .PHASES (PHASES)
  ) u_phase (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (running && !stall),
    .clr     (!running),
    .tick    (tick),
    .last    (phase_last)
  );

  // Commit target: same-cycle redirect bypasses the buffer, then buffer, then increment
  always_comb begin
    next_pc = pc_q + XLEN'(INC);
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (redir_pend_q) begin
      next_pc = redir_buf_q;
    end
  end

  // A halt request arriving on the commit cycle itself halts at that commit
  assign halt_now = halt_pend_q || halt_req;

  // Run/halt FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (run) state_d = RUN;
      RUN:     if (commit && halt_now) state_d = HALTED;
      HALTED:  if (run) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // PC, redirect buffer, halt latch and retired counter updates
  always_comb begin
    pc_d         = pc_q;
    redir_buf_d  = redir_buf_q;
    redir_pend_d = redir_pend_q;
    halt_pend_d  = halt_pend_q;
    retired_d    = retired_q;
    if (commit) begin
      pc_d         = next_pc;
      redir_pend_d = 1'b0;
      halt_pend_d  = 1'b0;
      retired_d    = retired_q + 32'd1;
    end else begin
      if (redirect_valid) begin
        redir_buf_d  = redirect_pc;
        redir_pend_d = 1'b1;
      end
      if (halt_req && state_q != IDLE) begin
        halt_pend_d = 1'b1;
      end
    end
  end

  // State registers; reset clears everything including pending requests
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      redir_buf_q  <= '0;
      redir_pend_q <= 1'b0;
      halt_pend_q  <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_buf_q  <= redir_buf_d;
      redir_pend_q <= redir_pend_d;
      halt_pend_q  <= halt_pend_d;
      retired_q    <= retired_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with a commit-PC scoreboard.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        run;
  logic        halt_req;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [2:0]  tick;
  logic        running;
  logic        commit;
  logic [31:0] retired;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  pc_sequencer #(
    .XLEN     (32),
    .PHASES   (7),
    .INC      (4),
    .RESET_PC (32'h0)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .run            (run),
    .halt_req       (halt_req),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .tick           (tick),
    .running        (running),
    .commit         (commit),
    .retired        (retired)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic h, input logic s,
                               input logic rv, input logic [31:0] rp);
    run            = r;
    halt_req       = h;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rp;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic advanceToTick(input int t, input int budget);
    int n = 0;
    while (tick != 3'(t) && n < budget) begin
      nextCycle();
      n++;
    end
    checkOutput("reach_tick", 64'(tick), 64'(t));
  endtask

  task automatic runUntilRetired(input int target, input int budget);
    int n = 0;
    while (retired != 32'(target) && n < budget) begin
      nextCycle();
      n++;
    end
    checkOutput("retire_wait", 64'(retired), 64'(target));
  endtask

  // Scoreboard monitor: each commit pops the expected PC, visible next cycle
  always @(negedge clock) begin
    if (reset_n === 1'b1 && commit === 1'b1) begin
      checkOutput("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        @(posedge clock);
        #1;
        checkOutput("commit_pc", 64'(pc), 64'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1 reset_n = 1'b0;
    #2;
    checkOutput("rst_pc", 64'(pc), 64'h0);
    checkOutput("rst_tick", 64'(tick), 64'h0);
    checkOutput("rst_running", 64'(running), 64'h0);
    checkOutput("rst_commit", 64'(commit), 64'h0);
    checkOutput("rst_retired", 64'(retired), 64'h0);
    nextCycle();
    nextCycle();
    reset_n = 1'b1;
    nextCycle();
    checkOutput("idle_hold", 64'(running), 64'h0);

    // Sequential stepping: three instructions of 7 phases each
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("start_running", 64'(running), 64'h1);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    for (int i = 0; i < 21; i++) begin
      checkOutput("seq_tick", 64'(tick), 64'(i % 7));
      checkOutput("seq_commit", 64'(commit), 64'(i % 7 == 6));
      nextCycle();
    end
    checkOutput("seq_retired", 64'(retired), 64'd3);
    checkOutput("seq_pc", 64'(pc), 64'hC);
    checkOutput("seq_tick0", 64'(tick), 64'h0);

    // Buffered redirect, then sequential increment from the target
    advanceToTick(2, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    runUntilRetired(5, 30);
    checkOutput("redir_pc", 64'(pc), 64'h104);

    // Earlier redirect overwritten by a same-cycle bypass on the commit cycle
    advanceToTick(1, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    advanceToTick(6, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h300);
    exp_q.push_back(32'h300);
    #1;
    checkOutput("bypass_commit", 64'(commit), 64'h1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("bypass_pc", 64'(pc), 64'h300);
    exp_q.push_back(32'h304);
    runUntilRetired(7, 20);
    checkOutput("pend_cleared_pc", 64'(pc), 64'h304);

    // Stall held on the last phase delays the commit
    advanceToTick(6, 10);
    exp_q.push_back(32'h308);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      #1;
      checkOutput("stall_commit", 64'(commit), 64'h0);
      checkOutput("stall_tick", 64'(tick), 64'h6);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("unstall_commit", 64'(commit), 64'h1);
    checkOutput("stall_retired", 64'(retired), 64'd7);
    nextCycle();
    checkOutput("stall_pc", 64'(pc), 64'h308);

    // Halt at the instruction boundary, redirect while halted, resume
    advanceToTick(3, 10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    exp_q.push_back(32'h30C);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    runUntilRetired(9, 20);
    checkOutput("halt_running", 64'(running), 64'h0);
    checkOutput("halt_tick", 64'(tick), 64'h0);
    checkOutput("halt_pc", 64'(pc), 64'h30C);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h400);
    exp_q.push_back(32'h400);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    checkOutput("halted_hold_pc", 64'(pc), 64'h30C);
    checkOutput("halted_commit", 64'(commit), 64'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("resume_running", 64'(running), 64'h1);
    checkOutput("resume_tick", 64'(tick), 64'h0);
    runUntilRetired(10, 20);
    checkOutput("resume_pc", 64'(pc), 64'h400);

    // Asynchronous reset mid-instruction with a redirect pending
    advanceToTick(2, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h500);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    advanceToTick(4, 10);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("arst_pc", 64'(pc), 64'h0);
    checkOutput("arst_tick", 64'(tick), 64'h0);
    checkOutput("arst_running", 64'(running), 64'h0);
    checkOutput("arst_retired", 64'(retired), 64'h0);
    nextCycle();
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_q.push_back(32'h4);
    runUntilRetired(1, 20);
    checkOutput("post_rst_pc", 64'(pc), 64'h4);

    nextCycle();
    checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter and phase sequencer for the multi-cycle CPU datapath. It holds the PC and steps a phase counter through `PHASES` cycles per instruction. On the last phase it commits a new PC: either the sequential increment or a buffered redirect target. It adds run/halt control, stall, redirect buffering and a retired-instruction counter, and drives phase timing for the ALU and fetch/decode logic.

## Interface
- `XLEN`, 32, PC and redirect width
- `PHASES`, 7, cycles per instruction (≥2)
- `INC`, 4, sequential PC increment
- `RESET_PC`, 0, PC value after reset
- `TW`, `$clog2(PHASES)`, phase counter width (derived, not overridden)

- `clock`  in  1  single clock, rising edge
- `reset_n`  in  1  reset, asynchronous assert, active-low
- `run`  in  1  start/resume request (level, sampled in IDLE/HALTED)
- `halt_req`  in  1  halt at next instruction boundary (pulse, latched)
- `stall`  in  1  freeze phase and PC this cycle (RUN only)
- `redirect_valid`  in  1  redirect target present this cycle
- `redirect_pc`  in  XLEN  redirect target
- `pc`  out  XLEN  current PC
- `tick`  out  TW  current phase, 0..PHASES-1
- `running`  out  1  state == RUN
- `commit`  out  1  one-cycle pulse: PC updated on this edge's cycle
- `retired`  out  32  committed-instruction count, wraps mod 2^32

## Operation
- FSM states: IDLE, RUN, HALTED (in `pc_seq_pkg`).
  - IDLE → RUN when `run`=1.
  - RUN → HALTED at a commit with halt pending.
  - HALTED → RUN when `run`=1.
- RUN, `stall`=0:
  - if `tick` < PHASES-1, `tick` increments.
  - else `tick`←0, `pc`←next_pc, `commit`=1, `retired`++.
- next_pc:
  - same-cycle `redirect_pc` if `redirect_valid`,
  - else buffered redirect if pending,
  - else `pc`+INC, truncated to XLEN, wrapping at 2^XLEN.
- Redirect buffer: one entry.
  - `redirect_valid` in any state on a non-commit cycle loads the entry and sets pending.
  - A later redirect overwrites the entry (last wins).
  - Pending clears at commit.
- `stall`=1 in RUN: `tick`, `pc`, `retired` hold and `commit`=0. Redirect and halt requests are still captured.
- `halt_req` captured in any state except IDLE, where it is ignored. It clears at the commit that halts.
- On entry to RUN, `tick` is 0. The PC is unchanged (RESET_PC from IDLE, committed value from HALTED).
- IDLE/HALTED: `tick`=0, `pc` holds, `commit`=0. A redirect captured here is applied at the first commit after resume.

## Timing
- Reset (`reset_n`=0, any time, including mid-instruction or with a redirect pending) takes effect immediately:
  - `pc`=RESET_PC, `tick`=0, state IDLE, `running`=0, `commit`=0, `retired`=0.
  - Redirect and halt pending are cleared.
- `run` sampled high in cycle N: `running`=1 and `tick`=0 in cycle N+1.
- Unstalled instruction period: exactly PHASES cycles. `commit` is high in the cycle where `tick`=PHASES-1. The new `pc` and `tick`=0 are visible the next cycle.
- `redirect_valid` on the commit cycle is bypassed into that commit, with zero added latency.
- `halt_req` on the commit cycle halts at that commit. `running`=0 the next cycle, with `pc` already updated.
- Simultaneous `stall` and last phase: no commit. The commit happens on the first unstalled cycle.
- `pc`, `tick` and `running` are registered outputs. `commit` is combinational from registered state and `stall` only.

## Structure
- `pc_seq_pkg`: state enum (IDLE, RUN, HALTED) and a phase-width helper function.
- Sub-module `phase_counter` (params PHASES; ports clock, reset_n, en, clr, tick, last). It is the natural split and is reused by the memory controller.
- The top holds the FSM, PC register, redirect buffer and retired counter.

## Test plan
- Reset then `run` pulse, PHASES=7, INC=4: `tick` goes 0..6 repeatedly. `pc` goes 0→4→8 with `commit` every 7th cycle. `retired`=3 after 21 cycles.
- Redirect 0x100 at `tick`=2: the next commit loads 0x100. The following commit loads 0x104. Pending is cleared.
- Redirects 0x200 at `tick`=1 then 0x300 at `tick`=6 (commit cycle): `pc`=0x300, with the bypass winning.
- `stall` held 5 cycles at `tick`=6: no commit, `tick` holds at 6. Commit occurs on the first unstalled cycle, so the period is 12 cycles.
- `halt_req` at `tick`=3: commit loads pc+4, then HALTED with `tick`=0. `run` resumes and `tick` restarts at 0.
- `reset_n` low at `tick`=4 with a redirect pending: outputs go immediately to `pc`=0, `tick`=0, IDLE. After `run`, the first commit yields 4, not the stale redirect.
